cdi_uart_rx_fifo: RTL and testbench
===================================

Name: cdi_uart_rx_fifo

Overview:
- Receive side of the SCC68070 debug UART.
- Consumes the serial line driven onto `scc68_uart_tx`, deserialises 8N1 frames and buffers the bytes in a show-ahead FIFO.
- A host-side reader (HPS bridge or the sim bench) drains the FIFO through a valid/ack handshake.
- Also reports sticky framing-error and overflow status so dropped console output is detectable.

Parameters:
- CLKS_PER_BIT, 3125, clock cycles per bit; 3125 gives 9600 baud at 30 MHz. Must be ≥ 4.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥ 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  system clock (clk30 domain)
- reset_n  input  1  asynchronous, active-low reset
- uart_rx  input  1  serial line from the SCC68070 TX; asynchronous, idles high
- rx_data  output  8  FIFO head byte; valid only while rx_valid = 1
- rx_valid  output  1  FIFO not empty
- rx_ack  input  1  pop the head byte; ignored while rx_valid = 0
- fifo_count  output  CNT_W  current occupancy, 0..FIFO_DEPTH
- framing_err  output  1  sticky: a stop bit was sampled low
- overflow  output  1  sticky: a byte was dropped because the FIFO was full
- err_clr  input  1  clears both sticky flags
- busy  output  1  receiver is inside a frame (state ≠ IDLE)

Behaviour:
- **Reset (async assert, sync release):**
  - Two-flop synchroniser and previous-sample register reset to 1.
  - State IDLE, bit counter 0.
  - FIFO pointers and count 0; rx_valid = 0, rx_data = 0, fifo_count = 0.
  - framing_err = 0, overflow = 0, busy = 0.
  - Asserting reset mid-frame aborts the frame with no push.
- **Synchroniser:** uart_rx passes through 2 flops; `rxs` is the second flop. All decisions use `rxs`, so there is 2 cycles of input latency.
- **State machine** (`ctr` counts clocks within a bit):
  - IDLE: a falling edge of `rxs` (previous = 1, current = 0) → START, ctr = 0.
  - START: when ctr = CLKS_PER_BIT/2 (integer division), sample `rxs`.
    - 0 → DATA, ctr = 0, bit index = 0.
    - 1 → IDLE (glitch rejected; no flag set).
  - DATA: when ctr = CLKS_PER_BIT−1, sample into the shift register LSB-first and reset ctr. After bit 7 → STOP.
  - STOP: when ctr = CLKS_PER_BIT−1, sample `rxs`.
    - 1 → push the byte.
    - 0 → set framing_err and discard the byte.
    - Either way → IDLE.
  - A line held low (break) after a framing error produces no new frame until `rxs` returns high and falls again.
- **Push timing:** the byte is written on the STOP sample cycle. rx_valid and fifo_count reflect it on the next cycle.
- **FIFO:**
  - Show-ahead: rx_data is the head entry, updated combinationally from the read pointer.
  - Pointers wrap modulo FIFO_DEPTH. Full means count = FIFO_DEPTH.
  - Pop occurs on a cycle where rx_ack = 1 and rx_valid = 1.
  - Push while full and no pop in that cycle: byte dropped, overflow set, pointers unchanged.
  - Push and pop in the same cycle: both happen and the count is unchanged. When full, the pushed byte is accepted with no overflow.
  - Push and pop in the same cycle when empty: the pop is ignored (rx_valid = 0) and the push is accepted.
- **Sticky flags:**
  - err_clr clears both flags on the next edge.
  - A set event in the same cycle as err_clr wins; the flag stays 1.
- **busy:** 1 in START, DATA and STOP.

Test Plan:
- CLKS_PER_BIT = 16. Send 0x55 then 0xA3 as 8N1 with 1 stop bit. Required: fifo_count = 2, rx_data = 0x55 with rx_valid = 1; after one rx_ack, rx_data = 0xA3; after a second ack, rx_valid = 0. No flags set.
- A 5-cycle low glitch on an idle line. Required: the receiver returns to IDLE, busy ≤ 8+2 cycles, fifo_count stays 0, framing_err = 0.
- Frame 0x7E with the stop bit driven low. Required: framing_err = 1, fifo_count = 0. Pulse err_clr → framing_err = 0. A following valid 0x12 is received correctly.
- FIFO_DEPTH = 4. Send 5 bytes (0x01..0x05) without acking. Required: fifo_count = 4, overflow = 1, and the drained order is 0x01..0x04.
- FIFO full. Hold rx_ack so the pop coincides with the STOP sample of byte 0x99. Required: overflow stays 0, count stays 4, and 0x99 emerges last.
- Assert reset_n low mid-DATA of a frame, then release. Required: all outputs return to reset values immediately; the next complete frame 0xC0 is received as 0xC0.

Source files
------------

// File: rtl/cdi_uart_rx_fifo.sv
// Receive side of the SCC68070 debug UART: 8N1 deserialiser feeding a show-ahead FIFO
// drained by a valid/ack reader, with sticky framing-error and overflow status.
module cdi_uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 3125,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             uart_rx,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic [CNT_W-1:0] fifo_count,
    output logic             framing_err,
    output logic             overflow,
    input  logic             err_clr,
    output logic             busy
);

    localparam int CTR_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(CLKS_PER_BIT / 2);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic             sync1;
    logic             rxs;
    logic             rxs_prev;
    state_t           state;
    state_t           state_next;
    logic [CTR_W-1:0] ctr;
    logic [CTR_W-1:0] ctr_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             push;
    logic             ferr_set;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             full;
    logic             do_push;
    logic             ovf_set;

    // The line idles high, so the synchroniser resets to 1 to avoid a false start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            sync1    <= uart_rx;
            rxs      <= sync1;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ctr     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            ctr     <= ctr_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    always_comb begin
        state_next   = state;
        ctr_next     = ctr;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        push         = 1'b0;
        ferr_set     = 1'b0;
        case (state)
            IDLE: begin
                ctr_next = '0;
                // Edge-triggered start: a held-low break cannot retrigger a frame.
                if (rxs_prev && !rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (ctr == CTR_HALF) begin
                    ctr_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rxs ? IDLE : DATA;
                end else begin
                    ctr_next = ctr + 1'b1;
                end
            end
            DATA: begin
                if (ctr == CTR_LAST) begin
                    ctr_next     = '0;
                    shift_next   = {rxs, shift[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    ctr_next = ctr + 1'b1;
                end
            end
            STOP: begin
                if (ctr == CTR_LAST) begin
                    ctr_next   = '0;
                    state_next = IDLE;
                    push       = rxs;
                    ferr_set   = !rxs;
                end else begin
                    ctr_next = ctr + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                ctr_next   = '0;
            end
        endcase
    end

    assign rx_valid = (count != '0);
    assign pop      = rx_ack && rx_valid;
    assign full     = (count == CNT_FULL);
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || pop);
    assign ovf_set  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Set events take priority over err_clr so no error can slip past a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            framing_err <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            framing_err <= ferr_set || (framing_err && !err_clr);
            overflow    <= ovf_set  || (overflow && !err_clr);
        end
    end

    assign rx_data    = rx_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_cdi_uart_rx_fifo.sv
// Directed bench for cdi_uart_rx_fifo with 16 clocks per bit and a 4-deep FIFO,
// covering ordered receive, glitch rejection, framing error, overflow and reset.
module tb_cdi_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset_n;
    logic             uart_rx;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ack;
    logic [CNT_W-1:0] fifo_count;
    logic             framing_err;
    logic             overflow;
    logic             err_clr;
    logic             busy;

    int n_compared;
    int n_mismatched;

    cdi_uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .fifo_count (fifo_count),
        .framing_err(framing_err),
        .overflow   (overflow),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected sequence completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame; optionally pulses rx_ack exactly on the receiver's stop-sample cycle,
    // which lands 155 edges after the edge that launched the start bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input bit ack_on_stop);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            @(posedge clk);
            #1 uart_rx = bits[b];
            for (int j = 0; j < CPB - 1; j++) begin
                @(posedge clk);
                #1;
                if (b == 9 && j == 10) rx_ack = ack_on_stop;
                if (b == 9 && j == 11) rx_ack = 1'b0;
            end
        end
        @(posedge clk);
        #1 uart_rx = 1'b1;
        idleCycles(4);
    endtask

    task automatic popByte();
        rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
    endtask

    task automatic pulseClear();
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    initial begin
        int          busy_cnt;
        logic [7:0]  exp_q[$];
        n_compared   = 0;
        n_mismatched = 0;
        reset_n = 1'b0;
        uart_rx = 1'b1;
        rx_ack  = 1'b0;
        err_clr = 1'b0;
        idleCycles(3);

        checkOutput("reset_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_count", 32'(fifo_count), 32'd0);
        checkOutput("reset_data", 32'(rx_data), 32'h00);
        checkOutput("reset_ferr", 32'(framing_err), 32'd0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idleCycles(5);

        $display("[TB] two frames in order");
        applyStimulus(8'h55, 1'b1, 1'b0);
        applyStimulus(8'hA3, 1'b1, 1'b0);
        checkOutput("t1_count", 32'(fifo_count), 32'd2);
        checkOutput("t1_valid", 32'(rx_valid), 32'd1);
        checkOutput("t1_head0", 32'(rx_data), 32'h55);
        popByte();
        checkOutput("t1_head1", 32'(rx_data), 32'hA3);
        popByte();
        checkOutput("t1_empty", 32'(rx_valid), 32'd0);
        checkOutput("t1_ferr", 32'(framing_err), 32'd0);
        checkOutput("t1_ovf", 32'(overflow), 32'd0);

        $display("[TB] short low glitch");
        busy_cnt = 0;
        uart_rx  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) uart_rx = 1'b1;
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
        end
        checkOutput("t2_busy_len_ok", 32'(busy_cnt > 0 && busy_cnt <= 10), 32'd1);
        checkOutput("t2_busy_end", 32'(busy), 32'd0);
        checkOutput("t2_count", 32'(fifo_count), 32'd0);
        checkOutput("t2_ferr", 32'(framing_err), 32'd0);

        $display("[TB] framing error then recovery");
        applyStimulus(8'h7E, 1'b0, 1'b0);
        checkOutput("t3_ferr_set", 32'(framing_err), 32'd1);
        checkOutput("t3_count", 32'(fifo_count), 32'd0);
        pulseClear();
        checkOutput("t3_ferr_clr", 32'(framing_err), 32'd0);
        applyStimulus(8'h12, 1'b1, 1'b0);
        checkOutput("t3_count2", 32'(fifo_count), 32'd1);
        checkOutput("t3_data", 32'(rx_data), 32'h12);
        checkOutput("t3_ferr_after", 32'(framing_err), 32'd0);
        popByte();

        $display("[TB] overflow on fifth byte");
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1, 1'b0);
        checkOutput("t4_count", 32'(fifo_count), 32'd4);
        checkOutput("t4_ovf", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("t4_drain%0d", i), 32'(rx_data), 32'(i));
            popByte();
        end
        checkOutput("t4_empty", 32'(rx_valid), 32'd0);
        pulseClear();
        checkOutput("t4_ovf_clr", 32'(overflow), 32'd0);

        $display("[TB] push coinciding with pop while full");
        exp_q = {};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'hA0 + 8'(i), 1'b1, 1'b0);
            exp_q.push_back(8'hA0 + 8'(i));
        end
        checkOutput("t5_full", 32'(fifo_count), 32'd4);
        applyStimulus(8'h99, 1'b1, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h99);
        checkOutput("t5_ovf", 32'(overflow), 32'd0);
        checkOutput("t5_count", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t5_drain%0d", i), 32'(rx_data), 32'(exp_q[i]));
            popByte();
        end
        checkOutput("t5_empty", 32'(rx_valid), 32'd0);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(8'h33, 1'b1, 1'b0);
        applyStimulus(8'h44, 1'b0, 1'b0);
        checkOutput("t6_pre_count", 32'(fifo_count), 32'd1);
        checkOutput("t6_pre_ferr", 32'(framing_err), 32'd1);
        uart_rx = 1'b0;
        idleCycles(16);
        uart_rx = 1'b1;
        idleCycles(16);
        uart_rx = 1'b0;
        idleCycles(10);
        checkOutput("t6_busy_mid", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_valid", 32'(rx_valid), 32'd0);
        checkOutput("t6_rst_count", 32'(fifo_count), 32'd0);
        checkOutput("t6_rst_data", 32'(rx_data), 32'h00);
        checkOutput("t6_rst_ferr", 32'(framing_err), 32'd0);
        uart_rx = 1'b1;
        idleCycles(3);
        reset_n = 1'b1;
        idleCycles(3);
        checkOutput("t6_post_count", 32'(fifo_count), 32'd0);
        applyStimulus(8'hC0, 1'b1, 1'b0);
        checkOutput("t6_c0_count", 32'(fifo_count), 32'd1);
        checkOutput("t6_c0_data", 32'(rx_data), 32'hC0);
        checkOutput("t6_c0_ferr", 32'(framing_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
